// File: rtl/noc_pkg.sv
// Definitions shared by the NoC switch blocks: packet type codes, link width and
// the output-port FSM states.
package noc_pkg;

  localparam int W = 8;

  localparam logic [2:0] READ_RESP  = 3'b011;
  localparam logic [2:0] WRITE_RESP = 3'b100;
  localparam logic [2:0] MESSAGE    = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    ACK_WAIT = 2'd2,
    STREAM   = 2'd3
  } out_port_state_t;

  // True for the packet type codes that may appear in a header byte.
  function automatic logic pkt_type_known(input logic [2:0] t);
    return (t == READ_RESP) || (t == WRITE_RESP) || (t == MESSAGE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping cyclically.
// Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int N_IN  = 4,
  parameter int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Doubling the vector turns the cyclic search into a linear scan starting at ptr.
  logic [2*N_IN-1:0] req_dbl;
  logic              found;

  assign req_dbl = {req, req};
  assign any     = |req;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (!found && req_dbl[int'(ptr) + k]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N_IN);
      end
    end
  end

endmodule

// File: rtl/switch_out_port.sv
// NoC switch output port: round-robin grant to one input FIFO, hold it for the
// whole packet and forward its byte stream onto the link with one register stage.
module switch_out_port #(
  parameter int N_IN        = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int W           = noc_pkg::W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0]   in_empty,
  input  logic [N_IN-1:0]   in_choose_next,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [N_IN-1:0]   in_cntl,
  output logic [N_IN-1:0]   grant,
  output logic [W-1:0]      out_data,
  output logic              out_cntl,
  output logic              out_valid,
  output logic              busy,
  output logic [15:0]       pkt_count
);

  import noc_pkg::*;

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  out_port_state_t   state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [15:0]       pkt_count_q, pkt_count_d;
  logic [W-1:0]      out_data_q, out_data_d;
  logic              out_cntl_q, out_cntl_d;
  logic              out_valid_q, out_valid_d;

  logic [W-1:0]      in_bytes [N_IN];
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [IDX_W-1:0]  sel_inc;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_unpack
      assign in_bytes[gi] = in_data[gi*W +: W];
    end
  endgenerate

  rr_arbiter #(
    .N_IN  (N_IN),
    .IDX_W (IDX_W)
  ) u_arb (
    .req (~in_empty),
    .ptr (rr_ptr_q),
    .idx (arb_idx),
    .any (arb_any)
  );

  // After serving (or abandoning) sel, the search starts at the next port.
  assign sel_inc = (sel_q == IDX_W'(N_IN - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    pkt_count_d = pkt_count_q;
    out_data_d  = '0;
    out_cntl_d  = 1'b1;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = GRANT;
          sel_d   = arb_idx;
        end
      end
      GRANT: begin
        state_d = ACK_WAIT;
        timer_d = '0;
      end
      ACK_WAIT: begin
        if (in_choose_next[sel_q]) begin
          state_d = STREAM;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_d  = IDLE;
          rr_ptr_d = sel_inc;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STREAM: begin
        // The byte presented alongside the falling choose_next is the last one.
        out_data_d  = in_bytes[sel_q];
        out_cntl_d  = in_cntl[sel_q];
        out_valid_d = 1'b1;
        if (!in_choose_next[sel_q]) begin
          state_d     = IDLE;
          rr_ptr_d    = sel_inc;
          pkt_count_d = pkt_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      timer_q     <= '0;
      pkt_count_q <= '0;
      out_data_q  <= '0;
      out_cntl_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      timer_q     <= timer_d;
      pkt_count_q <= pkt_count_d;
      out_data_q  <= out_data_d;
      out_cntl_q  <= out_cntl_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign grant     = (state_q == GRANT) ? (N_IN'(1) << sel_q) : '0;
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign out_cntl  = out_cntl_q;
  assign out_valid = out_valid_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_switch_out_port.sv
// Bench for switch_out_port: emulates the input stages, queues every forwarded
// byte when it is presented and checks the link against that queue.
module tb_switch_out_port;

  localparam int N_IN        = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int W           = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         cntl;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_IN-1:0]   in_empty;
  logic [N_IN-1:0]   in_cn;
  logic [N_IN*W-1:0] in_data;
  logic [N_IN-1:0]   in_cntl;
  logic [N_IN-1:0]   grant;
  logic [W-1:0]      out_data;
  logic              out_cntl;
  logic              out_valid;
  logic              busy;
  logic [15:0]       pkt_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;
  beat_t       exp_q[$];
  beat_t       mon_beat;
  logic [15:0] exp_pkt;
  logic [W-1:0] pb [16];
  logic         pc [16];

  switch_out_port #(
    .N_IN        (N_IN),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .W           (W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_empty       (in_empty),
    .in_choose_next (in_cn),
    .in_data        (in_data),
    .in_cntl        (in_cntl),
    .grant          (grant),
    .out_data       (out_data),
    .out_cntl       (out_cntl),
    .out_valid      (out_valid),
    .busy           (busy),
    .pkt_count      (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  // Link monitor: every valid byte must be the oldest queued one; idle link must read 0 / cntl 1.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      n_checks++;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data=%h cntl=%b, required no valid byte", out_data, out_cntl);
        end else begin
          mon_beat = exp_q.pop_front();
          if ({out_data, out_cntl} !== {mon_beat.data, mon_beat.cntl}) begin
            n_fail++;
            $display("FAIL link_beat: got data=%h cntl=%b, required data=%h cntl=%b",
                     out_data, out_cntl, mon_beat.data, mon_beat.cntl);
          end
        end
      end else if (out_valid !== 1'b0 || out_data !== '0 || out_cntl !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_link: got valid=%b data=%h cntl=%b, required valid=0 data=00 cntl=1",
                 out_valid, out_data, out_cntl);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_empty = '1;
    in_cn    = '0;
    in_data  = '0;
    in_cntl  = '1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_pkt = '0;
    mon_en  = 1'b1;
  endtask

  task automatic fill_pkt(input logic [2:0] ptype, input int len);
    pb[0] = {5'b00000, ptype};
    pc[0] = 1'b1;
    for (int i = 1; i < len; i++) begin
      pb[i] = W'($urandom_range(0, 255));
      pc[i] = 1'b0;
    end
  endtask

  task automatic wait_grant(input int port, output bit ok, output int waited);
    ok     = 1'b0;
    waited = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      waited = c + 1;
      if (grant !== '0) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL grant_timeout: got no grant in 40 cycles, required grant=%b", N_IN'(1) << port);
    end else if (grant !== (N_IN'(1) << port)) begin
      n_fail++;
      ok = 1'b0;
      $display("FAIL grant_value: got %b, required %b", grant, N_IN'(1) << port);
    end
  endtask

  // Input-stage model: accept the grant, present pb/pc one byte per cycle, and drop
  // choose_next together with the last byte.
  task automatic run_packet(input int port, input int len, input bit noise,
                            input bit drop_req, output int waited);
    bit    ok;
    beat_t nb;
    wait_grant(port, ok, waited);
    if (!ok) return;
    step();
    n_checks++;
    if (grant !== '0) begin
      n_fail++;
      $display("FAIL grant_pulse_width: got %b one cycle after grant, required 0000", grant);
    end
    in_cn[port] = 1'b1;
    for (int i = 0; i < len; i++) begin
      step();
      n_checks++;
      if (grant !== '0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_hold: byte %0d got grant=%b busy=%b, required grant=0000 busy=1", i, grant, busy);
      end
      in_data[port*W +: W] = pb[i];
      in_cntl[port]        = pc[i];
      nb.data = pb[i];
      nb.cntl = pc[i];
      exp_q.push_back(nb);
      if (i == len - 1) begin
        in_cn[port] = 1'b0;
        if (drop_req) in_empty[port] = 1'b1;
      end
      if (noise) begin
        in_data[0 +: W] = W'($urandom_range(0, 255));
        in_cntl[0]      = ~in_cntl[0];
        in_cn[3]        = ~in_cn[3];
      end
    end
    step();
    in_data[port*W +: W] = '0;
    in_cntl[port]        = 1'b1;
    if (noise) begin
      in_data[0 +: W] = '0;
      in_cntl[0]      = 1'b1;
      in_cn[3]        = 1'b0;
    end
    exp_pkt = exp_pkt + 16'd1;
    n_checks++;
    if (pkt_count !== exp_pkt) begin
      n_fail++;
      $display("FAIL pkt_count: got %h, required %h", pkt_count, exp_pkt);
    end
    $display("packet port=%0d len=%0d pkt_count=%h", port, len, pkt_count);
  endtask

  task automatic check_drained(input string tag);
    step();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drained_%s: got %0d bytes not forwarded, required 0", tag, exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (grant !== '0 || out_data !== '0 || out_cntl !== 1'b1 || out_valid !== 1'b0 ||
        busy !== 1'b0 || pkt_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: got grant=%b data=%h cntl=%b valid=%b busy=%b count=%h, required 0000 00 1 0 0 0000",
               grant, out_data, out_cntl, out_valid, busy, pkt_count);
    end
    $display("reset state grant=%b busy=%b pkt_count=%h", grant, busy, pkt_count);
  endtask

  task automatic test_single_request();
    int waited;
    do_reset();
    pb[0] = 8'h0B; pb[1] = 8'h02; pb[2] = 8'h01; pb[3] = 8'h02; pb[4] = 8'hAA; pb[5] = 8'hBB;
    pc[0] = 1'b1;  pc[1] = 1'b0;  pc[2] = 1'b0;  pc[3] = 1'b0;  pc[4] = 1'b0;  pc[5] = 1'b0;
    in_empty = 4'b1110;
    run_packet(0, 6, 1'b0, 1'b1, waited);
    check_drained("single");
    n_checks++;
    if (busy !== 1'b0 || grant !== '0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b grant=%b, required busy=0 grant=0000", busy, grant);
    end
  endtask

  task automatic test_round_robin();
    int waited;
    do_reset();
    in_empty = '0;
    for (int k = 0; k < 5; k++) begin
      fill_pkt(noc_pkg::WRITE_RESP, 4);
      run_packet(k % N_IN, 4, 1'b0, 1'b0, waited);
      if (k > 0) begin
        n_checks++;
        if (waited != 1) begin
          n_fail++;
          $display("FAIL rr_idle_dwell: got %0d cycles to next grant, required 1", waited);
        end
      end
    end
    in_empty = '1;
    check_drained("rr");
  endtask

  task automatic test_ack_timeout();
    bit ok;
    int waited;
    do_reset();
    in_empty = 4'b1011;
    wait_grant(2, ok, waited);
    in_empty[3] = 1'b0;
    for (int c = 1; c <= ACK_TIMEOUT; c++) begin
      step();
      n_checks++;
      if (busy !== 1'b1 || grant !== '0) begin
        n_fail++;
        $display("FAIL timeout_wait: cycle t+%0d got busy=%b grant=%b, required busy=1 grant=0000", c, busy, grant);
      end
    end
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: at t+%0d got busy=%b, required 0", ACK_TIMEOUT + 1, busy);
    end
    n_checks++;
    if (pkt_count !== exp_pkt) begin
      n_fail++;
      $display("FAIL timeout_count: got %h, required %h", pkt_count, exp_pkt);
    end
    $display("ack timeout port=2 pkt_count=%h", pkt_count);
    fill_pkt(noc_pkg::READ_RESP, 4);
    run_packet(3, 4, 1'b0, 1'b1, waited);
    in_empty = '1;
    check_drained("timeout");
  endtask

  task automatic test_noise();
    int waited;
    bit ok;
    do_reset();
    in_empty = 4'b1101;
    fill_pkt(noc_pkg::MESSAGE, 6);
    // Port 3 starts requesting only once port 1 holds the link.
    fork
      begin
        @(posedge clk);
        #2;
        in_empty[3] = 1'b0;
      end
    join_none
    run_packet(1, 6, 1'b1, 1'b1, waited);
    fill_pkt(noc_pkg::WRITE_RESP, 3);
    run_packet(3, 3, 1'b0, 1'b1, waited);
    check_drained("noise");
    ok = 1'b1;
  endtask

  task automatic test_reset_mid_stream();
    int    waited;
    bit    ok;
    beat_t nb;
    do_reset();
    in_empty = 4'b1110;
    fill_pkt(noc_pkg::WRITE_RESP, 4);
    run_packet(0, 4, 1'b0, 1'b1, waited);
    fill_pkt(noc_pkg::MESSAGE, 6);
    in_empty = 4'b1101;
    wait_grant(1, ok, waited);
    step();
    in_cn[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      in_data[1*W +: W] = pb[i];
      in_cntl[1]        = pc[i];
      nb.data = pb[i];
      nb.cntl = pc[i];
      exp_q.push_back(nb);
    end
    step();
    in_data[1*W +: W] = pb[2];
    in_cntl[1]        = pc[2];
    reset = 1'b1;
    step();
    reset    = 1'b0;
    in_cn    = '0;
    in_data  = '0;
    in_cntl  = '1;
    in_empty = 4'b1100;
    exp_pkt  = '0;
    n_checks++;
    if (out_valid !== 1'b0 || out_cntl !== 1'b1 || out_data !== '0 || grant !== '0 || pkt_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b cntl=%b data=%h grant=%b count=%h, required 0 1 00 0000 0000",
               out_valid, out_cntl, out_data, grant, pkt_count);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_beats: got %0d bytes not forwarded, required 0", exp_q.size());
    end
    $display("reset mid-stream pkt_count=%h", pkt_count);
    wait_grant(0, ok, waited);
    in_empty = '1;
  endtask

  task automatic test_wrap();
    int waited;
    do_reset();
    step();
    force dut.pkt_count_q = 16'hFFFE;
    step();
    step();
    release dut.pkt_count_q;
    exp_pkt = 16'hFFFE;
    step();
    n_checks++;
    if (pkt_count !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL wrap_preload: got %h, required fffe", pkt_count);
    end
    in_empty = 4'b1110;
    fill_pkt(noc_pkg::READ_RESP, 2);
    run_packet(0, 2, 1'b0, 1'b0, waited);
    fill_pkt(noc_pkg::READ_RESP, 2);
    run_packet(0, 2, 1'b0, 1'b1, waited);
    n_checks++;
    if (pkt_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap_zero: got %h, required 0000", pkt_count);
    end
    check_drained("wrap");
  endtask

  initial begin
    reset    = 1'b1;
    in_empty = '1;
    in_cn    = '0;
    in_data  = '0;
    in_cntl  = '1;
    exp_pkt  = '0;
    test_reset();
    test_single_request();
    test_round_robin();
    test_ack_timeout();
    test_noise();
    test_reset_mid_stream();
    test_wrap();
    mon_en = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
